// File: rtl/nibble_serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl_pkg
// Shared definitions for the nibble-serial adder controller:
//   - SLICE_W : width of the time-shared adder slice (one nibble)
//   - state_e : controller FSM states (IDLE, RUN, DONE)
//   - full_add: single-bit full adder used to build the ripple slice
// -----------------------------------------------------------------------------
package nibble_serial_add_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic p;
        p = x ^ y;
        return {(x & y) | (ci & p), p ^ ci};
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_slice_add4.sv
// -----------------------------------------------------------------------------
// slice_add4
// Combinational 4-bit ripple-carry adder built from a chain of full adders.
// Ports:
//   x, y  [3:0] in   nibble operands
//   cin         in   carry into bit 0
//   s     [3:0] out  nibble sum
//   cout        out  carry out of bit 3
// -----------------------------------------------------------------------------
module slice_add4
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    always_comb begin
        logic [SLICE_W:0] c;
        logic [1:0]       fa;
        // NOTE: every output and local gets a value on every pass through the
        // block before it is read, so no latch can be inferred.
        c    = '0;
        s    = '0;
        fa   = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            fa       = full_add(x[i], y[i], c[i]);
            s[i]     = fa[0];
            c[i+1]   = fa[1];
        end
        cout = c[SLICE_W];
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl
// Adds two W-bit operands (W = 4*N_SLICES) by time-sharing one 4-bit ripple
// slice over N_SLICES cycles, least-significant nibble first.
//
// Optional feature macro: SUB_EN
//   When defined, the Sub port exists; Sub=1 computes A-B (B nibbles inverted,
//   carry preloaded with 1). Cout=1 then means "no borrow".
//   When undefined, the block only adds.
//
// Ports:
//   Clk         in   system clock, rising edge
//   Reset       in   synchronous, active-high reset
//   Start       in   begin an operation; honoured only in IDLE
//   A, B  [W]   in   operands, captured on accepted Start
//   Sub         in   subtract select (SUB_EN only), captured on accepted Start
//   Sum   [W]   out  result register, held until the next accepted Start
//   Cout        out  carry out of the top slice
//   Busy        out  high while in RUN or DONE
//   Done        out  one-cycle pulse: Sum/Cout are valid
//
// Timing: Start accepted at edge 0 -> slices processed at edges 1..N_SLICES ->
// Done high during the cycle after edge N_SLICES.
// -----------------------------------------------------------------------------
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter  int N_SLICES = 4,
    localparam int W        = SLICE_W * N_SLICES
)(
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
`ifdef SUB_EN
    input  logic         Sub,
`endif
    output logic [W-1:0] Sum,
    output logic         Cout,
    output logic         Busy,
    output logic         Done
);

    localparam int CNT_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N_SLICES - 1);

    // Subtract request as seen by the controller; tied low when the feature
    // is compiled out so the datapath reduces to a plain adder.
    logic sub_in;
`ifdef SUB_EN
    assign sub_in = Sub;
`else
    assign sub_in = 1'b0;
`endif

    // ---------------------------------------------------------------- state
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             carry_q, carry_d;
    logic             sub_q,   sub_d;
    logic [W-1:0]     a_q,     a_d;
    logic [W-1:0]     b_q,     b_d;
    logic [W-1:0]     sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // ---------------------------------------------------------------- datapath
    logic [IDX_W-1:0]   slice_lsb;
    logic [SLICE_W-1:0] slice_x;
    logic [SLICE_W-1:0] slice_y;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;

    always_comb begin
        slice_lsb = IDX_W'(int'(cnt_q) * SLICE_W);
        slice_x   = a_q[slice_lsb +: SLICE_W];
        // Subtraction: one's complement of B here plus the carry preload of 1
        // gives the two's complement of B.
        slice_y   = b_q[slice_lsb +: SLICE_W] ^ {SLICE_W{sub_q}};
    end

    slice_add4 u_slice (
        .x    (slice_x),
        .y    (slice_y),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co)
    );

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    sub_d   = sub_in;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    cnt_d   = '0;
                    carry_d = sub_in;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end

            RUN: begin
                sum_d[slice_lsb +: SLICE_W] = slice_s;
                carry_d = slice_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SLICE) begin
                    // Cout is loaded with the same value the carry register
                    // takes, so it is already valid while Done is high.
                    cout_d  = slice_co;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                // Start is deliberately not examined here; it is only
                // accepted once back in IDLE.
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // computed before this edge, independent of statement order.
        if (Reset) begin
            // NOTE: these are ordinary flops (no RAM), so clearing every one
            // of them, operands included, costs nothing and keeps the
            // post-reset state fully defined.
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl
// Scoreboard bench: the driver pushes the hand-computed result and the cycle
// on which Done must appear; an independent monitor pops and compares on
// every Done pulse. Build with +define+SUB_EN to include subtraction vectors.
// -----------------------------------------------------------------------------
module tb_nibble_serial_add_ctrl;

    localparam int N_SLICES = 4;
    localparam int W        = 4 * N_SLICES;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           cyc;
    } exp_t;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         sub_tb;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Busy;
    logic         Done;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    nibble_serial_add_ctrl #(.N_SLICES(N_SLICES)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .A     (A),
        .B     (B),
`ifdef SUB_EN
        .Sub   (sub_tb),
`endif
        .Sum   (Sum),
        .Cout  (Cout),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got Done=1 with Sum=0x%0h, expected no Done (cycle %0d)", Sum, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum",        32'(Sum),  32'(e.sum));
                check("cout",       32'(Cout), 32'(e.cout));
                check("done_cycle", 32'(cyc),  32'(e.cyc));
            end
        end
    end

    // ---------------------------------------------------------------- driver
    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1;
            if (exp_q.size() == 0 && Busy === 1'b0 && Done === 1'b0) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL timeout: got %0d pending results, expected 0", exp_q.size());
        exp_q.delete();
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] exp_sum, input logic exp_cout);
        exp_t e;
        @(posedge Clk);
        #1;
        A      = a;
        B      = b;
        sub_tb = sub;
        Start  = 1'b1;
        @(posedge Clk);
        #1;
        Start  = 1'b0;
        e.sum  = exp_sum;
        e.cout = exp_cout;
        e.cyc  = cyc + N_SLICES;
        exp_q.push_back(e);
        check("busy_after_accept", 32'(Busy), 32'd1);
        wait_idle();
    endtask

    initial begin
        exp_t e;
        int   e0;

        Reset  = 1'b1;
        Start  = 1'b0;
        A      = '0;
        B      = '0;
        sub_tb = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_sum",  32'(Sum),  32'd0);
        check("reset_cout", 32'(Cout), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        Reset = 1'b0;

        // Plain additions, including full carry ripple and overflow.
        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);

        // Result holds in IDLE after completion.
        repeat (3) @(posedge Clk);
        #1;
        check("hold_sum",  32'(Sum),  32'h1000);
        check("hold_busy", 32'(Busy), 32'd0);

        // Second Start two cycles after the first is ignored.
        @(posedge Clk);
        #1;
        A = 16'h0001; B = 16'h0001; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start  = 1'b0;
        e.sum  = 16'h0002;
        e.cout = 1'b0;
        e.cyc  = cyc + N_SLICES;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        A = 16'h00FF; B = 16'h00FF; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        wait_idle();

        // Reset during slice 2 of 0x8888+0x8888 aborts with no Done.
        @(posedge Clk);
        #1;
        A = 16'h8888; B = 16'h8888; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        check("partial_sum", 32'(Sum), 32'h0010);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_sum",  32'(Sum),  32'd0);
        check("abort_done", 32'(Done), 32'd0);
        Reset = 1'b0;
        repeat (6) @(posedge Clk);
        run_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);

`ifdef SUB_EN
        run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);
`endif

        // Start held high: accept every six cycles with one IDLE gap.
        @(posedge Clk);
        #1;
        A = 16'h0102; B = 16'h0304; sub_tb = 1'b0; Start = 1'b1;
        @(posedge Clk);
        #1;
        e0 = cyc;
        e.cout = 1'b0;
        e.sum = 16'h0406; e.cyc = e0 + 4;  exp_q.push_back(e);
        e.sum = 16'h1304; e.cyc = e0 + 10; exp_q.push_back(e);
        e.sum = 16'h2304; e.cyc = e0 + 16; exp_q.push_back(e);
        A = 16'h1000;
        repeat (5) @(posedge Clk);
        #1;
        check("idle_gap_busy", 32'(Busy), 32'd0);
        @(posedge Clk);
        #1;
        check("reaccept_busy", 32'(Busy), 32'd1);
        A = 16'h2000;
        repeat (6) @(posedge Clk);
        #1;
        Start = 1'b0;
        wait_idle();

        repeat (3) @(posedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
